// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end: 10-bit word receive, 8-bit MISO read-back
module spi_slave #(
   parameter int RX_W      = 10,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [RX_W-1:0]      rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int RCW = $clog2(RX_W + 1);
   localparam int TCW = $clog2(ADDR_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [RX_W-1:0]      rx_sr;
   logic [RCW-1:0]       rx_cnt;
   logic [ADDR_SIZE-1:0] tx_sr;
   logic [TCW-1:0]       tx_cnt;
   logic                 tx_started;
   logic                 rd_addr_seen;
   logic                 rx_full;

   // Word is complete once RX_W bits have been shifted; later MOSI bits are ignored.
   assign rx_full = (rx_cnt == RCW'(RX_W));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: mode bit picks the receive state; SS_n high always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!SS_n) state_nxt = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n)              state_nxt = IDLE;
            else if (!MOSI)        state_nxt = WRITE;
            else if (rd_addr_seen) state_nxt = READ_DATA;
            else                   state_nxt = READ_ADD;
         end
         default: begin
            if (SS_n) state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: receive shift, rx strobe, read-address flag and MISO serialiser.
   // The shift register is loaded pre-shifted so bit7 appears on MISO the cycle after the latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sr        <= '0;
         rx_cnt       <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         tx_sr        <= '0;
         tx_cnt       <= '0;
         tx_started   <= 1'b0;
         rd_addr_seen <= 1'b0;
         MISO         <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n || state == IDLE || state == CHK_CMD) begin
            rx_sr      <= '0;
            rx_cnt     <= '0;
            tx_sr      <= '0;
            tx_cnt     <= '0;
            tx_started <= 1'b0;
            MISO       <= 1'b0;
         end else if (!rx_full) begin
            rx_sr  <= {rx_sr[RX_W-2:0], MOSI};
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == RCW'(RX_W - 1)) begin
               rx_data  <= {rx_sr[RX_W-2:0], MOSI};
               rx_valid <= 1'b1;
               if (state == READ_ADD) rd_addr_seen <= 1'b1;
            end
         end else if (state == READ_DATA) begin
            if (!tx_started) begin
               if (tx_valid) begin
                  MISO         <= tx_data[ADDR_SIZE-1];
                  tx_sr        <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                  tx_cnt       <= TCW'(ADDR_SIZE - 1);
                  tx_started   <= 1'b1;
                  rd_addr_seen <= 1'b0;
               end
            end else if (tx_cnt != '0) begin
               MISO   <= tx_sr[ADDR_SIZE-1];
               tx_sr  <= {tx_sr[ADDR_SIZE-2:0], 1'b0};
               tx_cnt <= tx_cnt - 1'b1;
            end else begin
               MISO <= 1'b0;
            end
         end else begin
            MISO <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [7:0] cur_tx;

   int vectors = 0;
   int errs    = 0;
   logic [9:0] sb[$];

   typedef struct {
      bit         mode;
      logic [9:0] word;
      logic [7:0] tx;
      bit         rd;
      bit         seen;
   } vec_t;

   vec_t vecs[8];

   spi_slave #(.RX_W(10), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   // Combinational RAM model: answers any 11-command word in the rx_valid cycle.
   assign tx_data  = cur_tx;
   assign tx_valid = rx_valid && (rx_data[9:8] == 2'b11);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         if (sb.size() == 0) chk("rx_valid_unexpected", 32'd1, 32'd0);
         else                chk("rx_data", {22'd0, rx_data}, {22'd0, sb.pop_front()});
      end
   end

   task automatic frame(input bit mode, input logic [9:0] w, input logic [7:0] tx,
                        input bit exp_rd, input bit exp_seen, input int abort_bits, input int rst_bit);
      logic exp_miso;
      cur_tx = tx;
      if (abort_bits < 0) sb.push_back(w);
      @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
      @(negedge clk); MOSI = mode;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("miso_rx_phase", MISO, 0);
         if (i == abort_bits) begin
            SS_n = 1'b1;
            @(negedge clk);
            chk("abort_state", dut.state, 0);
            chk("abort_seen", dut.rd_addr_seen, exp_seen);
            return;
         end
         MOSI = w[9-i];
      end
      @(negedge clk);
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         exp_miso = (exp_rd && k < 8) ? tx[7-k] : 1'b0;
         chk("miso_bit", MISO, exp_miso);
         MOSI = 1'($urandom);
         if (k == rst_bit) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_miso", MISO, 0);
            chk("rst_state", dut.state, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_seen", dut.rd_addr_seen, 0);
            @(negedge clk); SS_n = 1'b1; rst_n = 1'b1;
            return;
         end
      end
      SS_n = 1'b1;
      @(negedge clk);
      chk("end_state", dut.state, 0);
      chk("end_seen", dut.rd_addr_seen, exp_seen);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 10'h0A5, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 10'h13C, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 10'h2A5, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 10'h300, 8'h3C, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 10'h2A5, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 10'h3FF, 8'hFF, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 10'h3C3, 8'hA5, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 10'h000, 8'h81, 1'b0, 1'b0};

      rst_n  = 1'b0;
      SS_n   = 1'b1;
      MOSI   = 1'b0;
      cur_tx = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk("reset_miso", MISO, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_state", dut.state, 0);
      chk("reset_seen", dut.rd_addr_seen, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++)
         frame(vecs[v].mode, vecs[v].word, vecs[v].tx, vecs[v].rd, vecs[v].seen, -1, -1);

      // Abort after 6 shifted bits of a write, then a clean frame.
      frame(1'b0, 10'h0F0, 8'h00, 1'b0, 1'b0, 6, -1);
      frame(1'b0, 10'h155, 8'h00, 1'b0, 1'b0, -1, -1);

      // Reset on the third MISO bit; next mode-1 frame must be a READ_ADD.
      frame(1'b1, 10'h2AA, 8'h00, 1'b0, 1'b1, -1, -1);
      frame(1'b1, 10'h300, 8'h3C, 1'b1, 1'b0, -1, 2);
      frame(1'b1, 10'h2A5, 8'hFF, 1'b0, 1'b1, -1, -1);

      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end for the SPI RAM. Deserialises 10-bit command/address/data words from MOSI and presents them on rx_data with a one-cycle rx_valid strobe.
- On a read-data command, it captures the RAM's 8-bit tx_data when tx_valid is asserted and shifts it out MSB-first on MISO.
- The SPI bit clock is the system clock `clk`. MOSI is sampled, and MISO updated, on rising `clk`.

Parameters:
- RX_W, 10, width of one received word (2 command bits plus ADDR_SIZE payload).
- ADDR_SIZE, 8, width of tx_data and of the MISO read-back word.

Ports:
- clk  input  1  system/SPI clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; framing signal.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  RX_W  received word to RAM; bits [9:8] are the command.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  input  ADDR_SIZE  read data from RAM.
- tx_valid  input  1  tx_data valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counters=0, tx shift register=0, rd_addr_seen=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - If SS_n=0, go to CHK_CMD next cycle. Otherwise stay.
  - MISO=0, rx_valid=0.
- CHK_CMD:
  - MOSI is sampled as the mode bit and is not stored.
  - MOSI=0: go to WRITE.
  - MOSI=1 and rd_addr_seen=0: go to READ_ADD.
  - MOSI=1 and rd_addr_seen=1: go to READ_DATA.
- Receive phase (WRITE, READ_ADD and READ_DATA):
  - Shift MOSI into a 10-bit register MSB-first for exactly 10 cycles.
  - On the cycle the 10th bit is sampled, the full word is registered onto rx_data and rx_valid=1 in the following cycle, for exactly one cycle.
  - rx_data then holds until the next word completes.
- Command bits: the block does not check rx_data[9:8]. The host is responsible for encoding 00/01 in WRITE, 10 in READ_ADD and 11 in READ_DATA.
- READ_ADD: on completion, rd_addr_seen<=1.
- READ_DATA after the word is received:
  - Wait for tx_valid=1. In the first cycle it is seen, latch tx_data into the tx shift register and set rd_addr_seen<=0.
  - Starting the next cycle, drive MISO = tx[7], tx[6], ... tx[0], one bit per cycle, 8 cycles total. MISO returns to 0 afterwards.
  - The RAM is combinational, so tx_valid normally arrives in the same cycle as rx_valid. Reference latency from SS_n fall:
    - 1 cycle in IDLE, 1 in CHK_CMD, 10 shift cycles.
    - rx_valid on cycle 13.
    - tx latched on cycle 13.
    - MISO bit7 on cycle 14, bit0 on cycle 21.
- Completion: after a word (and read-back, if any) completes with SS_n still low, stay in the current state. Further MOSI bits are ignored, no additional rx_valid is raised and MISO=0, until SS_n rises.
- SS_n=1 in any non-IDLE state:
  - Go to IDLE next cycle and clear counters and the tx shift register. MISO=0.
  - No rx_valid for a partial word.
  - rd_addr_seen is preserved, except when a READ_DATA transfer is aborted after the tx latch, in which case it is already 0.
- Asynchronous reset mid-transfer: all outputs go immediately to their reset values. The next frame starts from IDLE, and rd_addr_seen=0 forces the next read to be treated as READ_ADD.
- tx_valid is ignored outside the READ_DATA wait window.

Test Plan:
- Write address: SS_n low; send mode 0 then 00_1010_0101. Required: rx_valid pulses exactly once with rx_data=0x0A5; MISO stays 0; SS_n high returns the FSM to IDLE.
- Write data: mode 0 then 01_0011_1100. Required: rx_data=0x13C with one rx_valid pulse. Then read address: mode 1 then 10_1010_0101. Required: rx_data=0x2A5 and rd_addr_seen=1.
- Read data: mode 1 then 11_0000_0000; the RAM model returns tx_data=0x3C with tx_valid in the rx_valid cycle. Required: MISO=0,0,1,1,1,1,0,0 on cycles 14-21, and rd_addr_seen=0 afterwards.
- Mode 1 sent with rd_addr_seen=0: FSM takes READ_ADD, not READ_DATA, and MISO remains 0 for the frame.
- Abort: SS_n high after 6 shifted bits of a WRITE frame. Required: no rx_valid, FSM in IDLE next cycle, and a following complete frame is received correctly.
- rst_n asserted on the 3rd MISO bit of a read. Required: MISO=0 and state=IDLE immediately (asynchronously); the next mode-1 frame is handled as READ_ADD.
